uart_tx_scheduler: RTL

Shares one `uart_transmitter` instance between `NUM_REQ` independent requesters using round-robin arbitration. Each requester supplies its own frame data and frame configuration: parity enable, stop-bit count and word length. The block latches the winning request and pulses the transmitter's `start` input. It then tracks the transmitter's `tx_busy` to frame completion before granting the next request. It sits directly upstream of the transmitter, between the transmitter and the UART command and host logic.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rr_arbiter.sv | 47 ++++
 rtl/uart_tx_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART transmit scheduler slice.
//   CFG_W         : width of one requester's frame configuration field
//   uart_cfg_t    : packed frame configuration {parity_en, two_stop_bits, word_length}
//   sched_state_e : scheduler FSM states
//   WL_5..WL_8    : word-length encodings understood by the transmitter
//   CFG_RESET     : configuration presented to the transmitter out of reset
package uart_pkg;

    localparam int CFG_W = 4;

    localparam logic [1:0] WL_5 = 2'b00;
    localparam logic [1:0] WL_6 = 2'b01;
    localparam logic [1:0] WL_7 = 2'b10;
    localparam logic [1:0] WL_8 = 2'b11;

    typedef struct packed {
        logic       parity_en;
        logic       two_stop_bits;
        logic [1:0] word_length;
    } uart_cfg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } sched_state_e;

    // The transmitter idles in 8-bit, no parity, one stop bit.
    localparam uart_cfg_t CFG_RESET = '{parity_en: 1'b0, two_stop_bits: 1'b0, word_length: WL_8};

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr and
// wraps, so the requester at ptr has highest priority this cycle.
//   req   : request vector, one bit per requester
//   ptr   : requester index where the search starts (must be < N)
//   grant : one-hot grant, all zero when nothing is requested
//   idx   : encoded index of the granted requester (0 when none)
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk the requesters starting at ptr; the first active one wins. The
    // extra bit on sum lets ptr+k exceed N-1 before being folded back, which
    // keeps the wrap correct for non-power-of-two N.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmitter between NUM_REQ requesters with round-robin
// arbitration. Latches the winner's data and frame configuration, pulses the
// transmitter start, then follows tx_busy until the frame completes.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is one-hot, IDLE only)
//   req_data, req_cfg : packed per-requester data and {parity, 2stop, wlen}
//   tx_*              : held data/config and start pulse to the transmitter
//   tx_busy           : transmitter busy flag
//   active_id         : requester currently being served
//   sched_busy        : high whenever the FSM is not in IDLE
//   frame_done        : one-cycle pulse at frame completion
//   err_timeout       : one-cycle pulse when the start is never acknowledged
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN adds a watchdog on the
// start acknowledge; without it err_timeout is constant 0.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH     = 8,
    parameter  int GAP_CYCLES     = 0,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*CFG_W-1:0]      req_cfg,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    output logic                          tx_parity_en,
    output logic                          tx_two_stop_bits,
    output logic [1:0]                    tx_word_length,
    input  logic                          tx_busy,
    output logic [ID_W-1:0]               active_id,
    output logic                          sched_busy,
    output logic                          frame_done,
    output logic                          err_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    sched_state_e          state_q;
    logic [ID_W-1:0]       rrPtr_q;
    logic [ID_W-1:0]       activeId_q;
    logic [DATA_WIDTH-1:0] txData_q;
    uart_cfg_t             txCfg_q;
    logic                  txStart_q;
    logic                  frameDone_q;
    logic [GAP_W-1:0]      gapCnt_q;

    logic [NUM_REQ-1:0]    grantOh;
    logic [ID_W-1:0]       winIdx;
    logic [ID_W-1:0]       rrPtr_d;
    logic [DATA_WIDTH-1:0] winData;
    uart_cfg_t             winCfg;
    logic                  accept;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] toCnt_q;
    logic            errTimeout_q;
    assign err_timeout = errTimeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    uart_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rrPtr_q),
        .grant (grantOh),
        .idx   (winIdx)
    );

    // Select the winner's data and configuration slices, and work out where
    // the next search should start (one past the winner, wrapping).
    always_comb begin
        winData = '0;
        winCfg  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == ID_W'(i)) begin
                winData = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                winCfg  = req_cfg[i*CFG_W +: CFG_W];
            end
        end
        rrPtr_d = (winIdx == ID_W'(NUM_REQ - 1)) ? '0 : winIdx + ID_W'(1);
    end

    // Grants only happen in IDLE with an idle transmitter. A busy line in
    // IDLE (stale or driven by someone else) holds everyone off, and ready
    // is forced low while reset is asserted.
    always_comb begin
        accept    = !rst && (state_q == S_IDLE) && !tx_busy && (|req_valid);
        req_ready = accept ? grantOh : '0;
    end

    // Main scheduler FSM. tx_start, frame_done and err_timeout are single-
    // cycle registered pulses, cleared by default every clock. Data and
    // config registers only load on acceptance, so they stay frozen for the
    // whole frame. WAIT_DONE spends one extra cycle to present frame_done
    // before leaving, so a new grant never coincides with frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rrPtr_q      <= '0;
            activeId_q   <= '0;
            txData_q     <= '0;
            txCfg_q      <= CFG_RESET;
            txStart_q    <= 1'b0;
            frameDone_q  <= 1'b0;
            gapCnt_q     <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            toCnt_q      <= '0;
            errTimeout_q <= 1'b0;
`endif
        end else begin
            txStart_q    <= 1'b0;
            frameDone_q  <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            errTimeout_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        txData_q   <= winData;
                        txCfg_q    <= winCfg;
                        activeId_q <= winIdx;
                        rrPtr_q    <= rrPtr_d;
                        txStart_q  <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    toCnt_q <= '0;
`endif
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        errTimeout_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        toCnt_q <= toCnt_q + TO_W'(1);
                    end
`else
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end
`endif
                end
                S_WAIT_DONE: begin
                    if (frameDone_q) begin
                        if (GAP_CYCLES > 0) begin
                            gapCnt_q <= '0;
                            state_q  <= S_GAP;
                        end else begin
                            state_q  <= S_IDLE;
                        end
                    end else if (!tx_busy) begin
                        frameDone_q <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gapCnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + GAP_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data          = txData_q;
    assign tx_start         = txStart_q;
    assign tx_parity_en     = txCfg_q.parity_en;
    assign tx_two_stop_bits = txCfg_q.two_stop_bits;
    assign tx_word_length   = txCfg_q.word_length;
    assign active_id        = activeId_q;
    assign sched_busy       = (state_q != S_IDLE);
    assign frame_done       = frameDone_q;

endmodule
